// File: rtl/shift_reg_sipo_rx.sv
// shift_reg_sipo_rx
//   Receive-side deserializer. Collects a valid/ready serial bit stream into
//   WIDTH-bit parallel words presented on a valid/ready output. The output
//   word sits in its own slot, so the next word can shift in while the
//   current one waits for downstream.
//
// Parameters
//   WIDTH      bits per parallel word (>= 2)
//   MSB_FIRST  1: first received bit lands in m_data[WIDTH-1]
//              0: first received bit lands in m_data[0]
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   s_valid  in   serial bit valid
//   s_bit    in   serial data bit
//   s_ready  out  serial bit accepted when s_valid && s_ready
//   m_valid  out  parallel word valid
//   m_data   out  parallel word
//   m_ready  in   word consumed when m_valid && m_ready
//   busy     out  partial word in progress (bit count != 0)

module shift_reg_sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 received bits ever need storing: the completing bit goes
    // straight from s_bit into the assembled word.
    logic [WIDTH-2:0] part;
    logic [WIDTH-1:0] word;   // part with the current s_bit shifted in
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;

    assign last_bit = (cnt == LAST);

    // A completing bit needs somewhere to go: the slot must be empty or be
    // drained on this same edge. Earlier bits never wait.
    assign s_ready = !reset && (!last_bit || !m_valid || m_ready);
    assign accept  = s_valid && s_ready;
    assign busy    = (cnt != '0);

    generate
        if (MSB_FIRST) begin : g_msb
            assign word = {part, s_bit};
        end else begin : g_lsb
            assign word = {s_bit, part};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            part    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (accept) begin
                part <= MSB_FIRST ? word[WIDTH-2:0] : word[WIDTH-1:1];
                cnt  <= last_bit ? '0 : cnt + CW'(1);
            end
            // A new word landing on the same edge as a drain replaces the old
            // one and keeps m_valid high, giving bubble-free back-to-back words.
            if (accept && last_bit) begin
                m_data  <= word;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
module tb_shift_reg_sipo_rx;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst, sv, sb, mr;

    logic         s_ready1, m_valid1, busy1;
    logic [W-1:0] m_data1;
    logic         s_ready0, m_valid0, busy0;
    logic [W-1:0] m_data0;

    always #5 clk = ~clk;

    shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(rst), .s_valid(sv), .s_bit(sb), .s_ready(s_ready1),
        .m_valid(m_valid1), .m_data(m_data1), .m_ready(mr), .busy(busy1)
    );

    shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(rst), .s_valid(sv), .s_bit(sb), .s_ready(s_ready0),
        .m_valid(m_valid0), .m_data(m_data0), .m_ready(mr), .busy(busy0)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // scoreboard: expected words for each ordering
    logic [W-1:0] q_msb[$];
    logic [W-1:0] q_lsb[$];
    logic [W-1:0] w_msb, w_lsb;
    int           mcnt;
    int           pushed, popped;
    int           mv_seen, sr_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle. Entered just after a falling edge with inputs set;
    // samples 1 time unit later, updates the model, and returns after the
    // next falling edge.
    task automatic tick();
        logic acc, take, exp_sr;
        #1;
        exp_sr = !rst && (mcnt != W - 1 || q_msb.size() == 0 || mr);
        chk("s_ready_msb", s_ready1, exp_sr);
        chk("s_ready_lsb", s_ready0, exp_sr);
        chk("m_valid_msb", m_valid1, q_msb.size() != 0);
        chk("m_valid_lsb", m_valid0, q_lsb.size() != 0);
        chk("busy_msb", busy1, mcnt != 0);
        chk("busy_lsb", busy0, mcnt != 0);
        if (m_valid1) mv_seen++;
        if (!s_ready1) sr_low++;
        acc  = sv && s_ready1;
        take = m_valid1 && mr;
        if (rst) begin
            q_msb.delete();
            q_lsb.delete();
            mcnt = 0;
        end else begin
            if (take) begin
                if (q_msb.size() == 0) begin
                    chk("spurious_word", 1, 0);
                end else begin
                    chk("word_msb", m_data1, q_msb.pop_front());
                    chk("word_lsb", m_data0, q_lsb.pop_front());
                    popped++;
                end
            end
            if (acc) begin
                w_msb[W-1-mcnt] = sb;
                w_lsb[mcnt]     = sb;
                mcnt++;
                if (mcnt == W) begin
                    q_msb.push_back(w_msb);
                    q_lsb.push_back(w_lsb);
                    pushed++;
                    mcnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic b);
        sv = 1'b1;
        sb = b;
        tick();
    endtask

    task automatic idle(input int n);
        sv = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [W-1:0] pat;
        int           guard;
        mcnt = 0; pushed = 0; popped = 0; mv_seen = 0; sr_low = 0;
        w_msb = '0; w_lsb = '0;
        rst = 1'b1; sv = 1'b0; sb = 1'b0; mr = 1'b1;
        @(negedge clk);
        tick();
        tick();
        // reset state (reset still high)
        chk("rst_m_valid", m_valid1, 0);
        chk("rst_m_data", m_data1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_s_ready", s_ready1, 0);
        rst = 1'b0;
        idle(2);

        // 1: MSB-first / LSB-first word 1,0,1,1 with m_ready=1
        send(1); send(0); send(1); send(1);
        sv = 1'b0;
        chk("t1_valid", m_valid1, 1);
        chk("t1_data_msb", m_data1, 4'b1011);
        chk("t1_data_lsb", m_data0, 4'b1101);
        tick();
        chk("t1_one_cycle", m_valid1, 0);
        idle(2);

        // 2: same bits with a 3-cycle gap between bits 2 and 3
        send(1); send(0);
        sv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_busy_gap", busy0, 1);
        end
        send(1); send(1);
        sv = 1'b0;
        chk("t2_data_lsb", m_data0, 4'b1101);
        chk("t2_data_msb", m_data1, 4'b1011);
        idle(2);

        // 3: back-pressure, 1011 then 0110
        mr = 1'b0;
        send(1); send(0); send(1); send(1);
        send(0); send(1); send(1);
        chk("t3_busy", busy1, 1);
        sv = 1'b1; sb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t3_stall_s_ready", s_ready1, 0);
            chk("t3_held_data", m_data1, 4'b1011);
            @(negedge clk);
        end
        mr = 1'b1;
        tick();
        mr = 1'b0; sv = 1'b0;
        chk("t3_still_valid", m_valid1, 1);
        chk("t3_new_msb", m_data1, 4'b0110);
        chk("t3_new_lsb", m_data0, 4'b0110);
        mr = 1'b1;
        idle(2);

        // 4: continuous alternating 4'hA / 4'h5
        mv_seen = 0; sr_low = 0;
        for (int w = 0; w < 4; w++) begin
            pat = (w % 2 == 0) ? 4'hA : 4'h5;
            for (int k = W - 1; k >= 0; k--) send(pat[k]);
        end
        idle(1);
        chk("t4_words", mv_seen, 4);
        chk("t4_s_ready_low", sr_low, 0);
        idle(1);

        // 5: reset mid-word
        send(1); send(1);
        sv = 1'b0; rst = 1'b1;
        tick();
        chk("t5_rst_valid", m_valid1, 0);
        chk("t5_rst_busy", busy1, 0);
        chk("t5_rst_data", m_data1, 0);
        chk("t5_rst_s_ready", s_ready1, 0);
        rst = 1'b0;
        send(0); send(1); send(1); send(0);
        sv = 1'b0;
        chk("t5_data", m_data1, 4'b0110);
        idle(2);

        // 6: random back-pressure, 200 words
        pushed = 0; popped = 0; guard = 0;
        while (pushed < 200 && guard < 20000) begin
            sv = ($urandom_range(0, 3) != 0);
            sb = $urandom_range(0, 1);
            mr = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        chk("t6_sent_in_budget", pushed >= 200, 1);
        sv = 1'b0; mr = 1'b1;
        guard = 0;
        while (q_msb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        chk("t6_drained", q_msb.size(), 0);
        chk("t6_count", popped, pushed);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
